// File: rtl/onchip_mem_pkg.sv
// ----------------------------------------------------------------------------
// onchip_mem_pkg
// Shared constants and types for the two-master on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : word address, data and byte-lane widths
//   NUM_WORDS              : implemented RAM depth (higher addresses are
//                            out of range)
//   OOR_DATA               : value returned for out-of-range reads
//   midx_t                 : master index (0 = Nios data master,
//                            1 = pong video/sprite reader)
//   mem_req_t              : one master's request bundle
// ----------------------------------------------------------------------------
package onchip_mem_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 32000;

  localparam logic [DATA_W-1:0] OOR_DATA = 32'h0000_0000;

  typedef logic midx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
  } mem_req_t;

endpackage : onchip_mem_pkg

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter with its priority pointer register.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request per master (already qualified by the caller)
//   accept       : a grant was taken this cycle; advances the pointer
//   grant[1:0]   : one-hot (or zero) grant, combinational from req/pointer
// After reset the pointer favours master 0.
// ----------------------------------------------------------------------------
module rr_arbiter2
  import onchip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  midx_t rr_ptr_q;
  midx_t rr_ptr_d;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | (rr_ptr_q == 1'b0));
    grant[1] = req[1] & (~req[0] | (rr_ptr_q == 1'b1));
  end

  // After an accept, priority passes to the master that was not granted:
  // granting master 0 points at 1, granting master 1 points at 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM between two Avalon-MM masters.
//   clk, reset_n            : clock, asynchronous active-low reset
//   m0_* / m1_*             : Avalon-MM slave ports (address, read, write,
//                             writedata, byteenable, waitrequest, readdata,
//                             readdatavalid); m0 = Nios data, m1 = pong video
//   mem_*                   : RAM port (address, chipselect, write, writedata,
//                             byteenable, clken, readdata with 1-clk latency)
// One access is granted per clock (round-robin), accepted with zero wait, and
// read data comes back exactly one clock later tagged to its owner.
// Out-of-range writes are dropped; out-of-range reads return OOR_DATA.
// ----------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int                ADDR_W    = onchip_mem_pkg::ADDR_W,
  parameter int                DATA_W    = onchip_mem_pkg::DATA_W,
  parameter int                BE_W      = onchip_mem_pkg::BE_W,
  parameter int                NUM_WORDS = onchip_mem_pkg::NUM_WORDS,
  parameter logic [DATA_W-1:0] OOR_DATA  = onchip_mem_pkg::OOR_DATA
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  import onchip_mem_pkg::*;

  // Goes high on the first edge after reset release; until then nothing is
  // granted and both masters are stalled.
  logic ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Request bundles. read+write together is illegal and is treated as a write.
  mem_req_t   mreq [2];
  logic [1:0] req;
  logic [1:0] req_gated;
  logic [1:0] grant;
  logic       grant_any;
  midx_t      sel;

  always_comb begin
    mreq[0] = '{addr: m0_address, wdata: m0_writedata, be: m0_byteenable,
                rd: m0_read & ~m0_write, wr: m0_write};
    mreq[1] = '{addr: m1_address, wdata: m1_writedata, be: m1_byteenable,
                rd: m1_read & ~m1_write, wr: m1_write};
  end

  assign req       = {m1_read | m1_write, m0_read | m0_write};
  assign req_gated = req & {2{ready_q}};
  assign grant_any = |grant;
  assign sel       = grant[1];

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_gated),
    .accept  (grant_any),
    .grant   (grant)
  );

  assign m0_waitrequest = ~ready_q | (req[0] & ~grant[0]);
  assign m1_waitrequest = ~ready_q | (req[1] & ~grant[1]);

  // RAM drive from the winning master.
  mem_req_t win;
  logic     in_range;
  logic     accept_rd;

  assign win       = mreq[sel];
  assign in_range  = int'(win.addr) < NUM_WORDS;
  assign accept_rd = grant_any & win.rd;

  assign mem_address    = win.addr;
  assign mem_writedata  = win.wdata;
  assign mem_byteenable = win.be;
  assign mem_chipselect = grant_any & in_range;
  assign mem_write      = grant_any & win.wr & in_range;
  assign mem_clken      = ready_q;

  // Read-return tracking: one slot suffices because latency is exactly one
  // clock, so a new accept and the previous return never overlap in state.
  logic  rd_pend_q, rd_pend_d;
  midx_t rd_tag_q,  rd_tag_d;
  logic  rd_oor_q,  rd_oor_d;

  always_comb begin
    rd_pend_d = accept_rd;
    rd_tag_d  = rd_tag_q;
    rd_oor_d  = rd_oor_q;
    if (accept_rd) begin
      rd_tag_d = sel;
      rd_oor_d = ~in_range;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      rd_oor_q  <= rd_oor_d;
    end
  end

  logic [DATA_W-1:0] ret_data;
  assign ret_data = rd_oor_q ? OOR_DATA : mem_readdata;

  // Per-master return path. Outside its valid cycle each readdata shows the
  // last value it delivered.
  logic              rvalid    [2];
  logic [DATA_W-1:0] rdata_out [2];
  logic [DATA_W-1:0] rdata_q   [2];
  logic [DATA_W-1:0] rdata_d   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid[gi]    = rd_pend_q & (rd_tag_q == 1'(gi));
    assign rdata_out[gi] = rvalid[gi] ? ret_data : rdata_q[gi];
    assign rdata_d[gi]   = rdata_out[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q[gi] <= '0;
      end else begin
        rdata_q[gi] <= rdata_d[gi];
      end
    end
  end

  assign m0_readdatavalid = rvalid[0];
  assign m0_readdata      = rdata_out[0];
  assign m1_readdatavalid = rvalid[1];
  assign m1_readdata      = rdata_out[1];

  // read and write together from one master is a protocol violation.
  a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(m0_read && m0_write));
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(m1_read && m1_write));

endmodule : onchip_mem_arbiter
